// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: 1-cycle logic/arith ops, 32-iteration MULT and DIV engines with HI/LO.
// Optional divider datapath enabled by defining ALU_EXEC_DIV_EN.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_MULT = 4'b1001;
`ifdef ALU_EXEC_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'b1010;
`endif
    localparam logic [3:0] OP_MFHI = 4'b1011;
    localparam logic [3:0] OP_MFLO = 4'b1100;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef ALU_EXEC_DIV_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_FIX, S_DONE} state_t;
`endif

    state_t state, state_d;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 neg_q;
    logic [WIDTH-1:0]     hi, lo;
    logic [WIDTH-1:0]     res_q;
    logic                 zero_q, ill_q;
`ifdef ALU_EXEC_DIV_EN
    logic                 is_div, neg_r, dz;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH:0]       div_sh, div_dif;
    logic                 div_ge;
`endif

    logic                 accept;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ill;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    assign in_ready  = (state == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
`ifdef ALU_EXEC_DIV_EN
    assign busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
`else
    assign busy      = (state == S_MUL) || (state == S_FIX);
`endif
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

    assign abs_a = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b = src_b[WIDTH-1] ? -src_b : src_b;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_MULT: alu_res = '0;
`ifdef ALU_EXEC_DIV_EN
            OP_DIV:  alu_res = '0;
`endif
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_ill = 1'b1;
        endcase
    end

    // Multiplier: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

`ifdef ALU_EXEC_DIV_EN
    // Divider: acc = {remainder, dividend/quotient}, shifted left each step.
    assign div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_dif = div_sh - {1'b0, opnd};
    assign div_ge  = ~div_dif[WIDTH];
`endif

    always_comb begin
        prod_s = neg_q ? -acc : acc;
        fix_hi = prod_s[2*WIDTH-1:WIDTH];
        fix_lo = prod_s[WIDTH-1:0];
`ifdef ALU_EXEC_DIV_EN
        if (is_div) begin
            if (dz) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (alu_ctrl == OP_MULT) state_d = S_MUL;
`ifdef ALU_EXEC_DIV_EN
                    else if (alu_ctrl == OP_DIV) state_d = S_DIV;
`endif
                    else state_d = S_DONE;
                end
            end
            S_MUL:   if (cnt == CNT_LAST) state_d = S_FIX;
`ifdef ALU_EXEC_DIV_EN
            S_DIV:   if (cnt == CNT_LAST) state_d = S_FIX;
`endif
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            ill_q  <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
            is_div <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            a_q    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        neg_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
`ifdef ALU_EXEC_DIV_EN
                        is_div <= (alu_ctrl == OP_DIV);
                        neg_r  <= src_a[WIDTH-1];
                        dz     <= (src_b == '0);
                        a_q    <= src_a;
`endif
                        if (alu_ctrl == OP_MULT) begin
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                            opnd <= abs_a;
                        end
`ifdef ALU_EXEC_DIV_EN
                        else if (alu_ctrl == OP_DIV) begin
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                            opnd <= abs_b;
                        end
`endif
                        else begin
                            res_q  <= alu_res;
                            zero_q <= (alu_res == '0);
                            ill_q  <= alu_ill;
                        end
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
`ifdef ALU_EXEC_DIV_EN
                S_DIV: begin
                    acc <= {div_ge ? div_dif[WIDTH-1:0] : div_sh[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
                    cnt <= cnt + 1'b1;
                end
`endif
                S_FIX: begin
                    hi     <= fix_hi;
                    lo     <= fix_lo;
                    res_q  <= fix_lo;
                    zero_q <= (fix_lo == '0);
                    ill_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Execute-stage arithmetic unit for the MIPS pipeline.
- Consumes the 4-bit ALU control code produced by the ALU control decoder, together with two 32-bit operands.
- Single-cycle logic/arithmetic ops return a registered result one cycle after acceptance.
- MULT/DIV run as 32-iteration sequential engines that stall the pipeline through a valid/ready handshake and update the HI/LO registers.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation request from ID/EX
- in_ready  out  1  unit can accept; high only in IDLE
- alu_ctrl  in  4  operation code
- src_a  in  WIDTH  operand A (rs)
- src_b  in  WIDTH  operand B (rt)
- out_valid  out  1  one-cycle pulse, result valid
- result  out  WIDTH  operation result
- zero  out  1  result == 0, qualified by out_valid
- illegal  out  1  unsupported code, qualified by out_valid
- busy  out  1  multi-cycle op in flight (pipeline stall)

## Operation
Codes:
- 0000 ADD, wraps, no overflow trap
- 0001 SUB
- 0010 AND
- 0011 OR
- 0100 XOR
- 0110 NOR
- 1000 SLT, signed, result 1/0
- 1001 MULT, signed, HI:LO = A*B, result = LO
- 1010 DIV, signed, LO = quotient, HI = remainder, result = LO
- 1011 MFHI, result = HI
- 1100 MFLO, result = LO
- Any other code: result 0, illegal = 1, single-cycle latency

State machine:
- IDLE: handshake accepts when in_valid && in_ready.
  - Single-cycle codes → DONE.
  - MULT → MUL.
  - DIV → DIV.
- MUL: shift-add on operand magnitudes, one bit per cycle, 32 cycles → FIX.
- DIV: restoring divide on magnitudes, one quotient bit per cycle, 32 cycles → FIX.
- FIX: applies sign correction and writes HI/LO → DONE.
- DONE: out_valid = 1 for one cycle → IDLE.

Arithmetic rules:
- Product sign is sign(A) XOR sign(B).
- Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = src_a, normal latency, illegal = 0.
- 0x80000000 / −1: LO = 0x80000000, HI = 0.

Other rules:
- Operands and code are captured at acceptance; later changes on src_a/src_b/alu_ctrl are ignored.
- in_valid while busy is not accepted; the requester holds its request.

## Timing
Latency from the acceptance edge to out_valid:
- Single-cycle ops: 1 cycle.
- MULT/DIV: 34 cycles (32 iterations + FIX + DONE).

Handshake and status signals:
- in_ready is low from the acceptance edge until the cycle after out_valid.
- Throughput: one single-cycle op every 2 cycles (IDLE/DONE alternate).
- busy is high in MUL, DIV and FIX.

Outputs and registers:
- result/zero/illegal hold their last values outside out_valid.
- HI/LO update only on the FIX edge.
- MFHI/MFLO issued immediately after a MULT/DIV completes read the new values.

Reset (rst_n low at a clk edge):
- Goes to IDLE; aborts any in-flight op.
- HI = LO = 0, result = 0, out_valid = zero = illegal = busy = 0.
- in_ready = 1 from the first cycle after reset is released.

## Configuration
- ALU_EXEC_DIV_EN defined: the divider datapath and DIV state are compiled in; code 1010 behaves as above.
- Undefined: code 1010 is illegal (result 0, illegal = 1, 1-cycle latency), HI/LO are untouched, and no divider logic is synthesized.
- MULT is always present.

## Test plan
- Reset: hold rst_n low 2 cycles mid-MULT → in_ready = 1, busy = 0, out_valid = 0; a following MFHI returns 0.
- Single-cycle ops:
  - ADD 0x7FFFFFFF + 1 → result 0x80000000, 1 cycle later.
  - SUB 5 − 5 → zero = 1.
  - SLT −1 < 1 → result 1.
  - NOR 0 → result 0xFFFFFFFF.
- MULT −3 × 7 accepted at cycle 0:
  - busy for cycles 1–33; out_valid at cycle 34; result 0xFFFFFFEB.
  - MFHI then returns 0xFFFFFFFF.
  - in_valid held during busy is not accepted.
- DIV (macro defined):
  - −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - 9 / 0 → LO = 0xFFFFFFFF, HI = 9.
- Macro undefined: DIV 8 / 2 → illegal = 1, result 0 after 1 cycle; HI/LO unchanged from the prior MULT.
- Illegal code 1111 → illegal = 1, result 0; the next ADD 2 + 3 is accepted and returns 5.
